// File: rtl/gen_context_pkt_mc.sv
// Multi-channel VITA context packet generator: per-channel event capture,
// round-robin grant and serialisation onto one 36-bit SOF/EOF stream.
module gen_context_pkt_mc #(
    parameter int          NUM_CHAN       = 2,
    parameter int          MSG_WORDS      = 1,
    parameter int          PROT_ENG_FLAGS = 1,
    parameter logic [3:0]  PORT_BASE      = 4'd3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clear,
    input  logic [NUM_CHAN-1:0]           trigger,
    input  logic [NUM_CHAN*32*MSG_WORDS-1:0] message,
    input  logic [NUM_CHAN*32-1:0]        streamid,
    input  logic [NUM_CHAN*32-1:0]        seqnum,
    input  logic [63:0]                   vita_time,
    output logic [35:0]                   data_o,
    output logic                          src_rdy_o,
    input  logic                          dst_rdy_i,
    output logic [NUM_CHAN-1:0]           sent,
    output logic [NUM_CHAN-1:0]           dropped
);

    localparam int LEN = 5 + MSG_WORDS;
    localparam int MW  = 32 * MSG_WORDS;
    localparam int CW  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int IW  = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PROT, S_HDR, S_SID, S_TICS, S_TICS2, S_MSG, S_FLOW
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 go_q;
    logic [CW-1:0]        rr_q;
    logic [NUM_CHAN-1:0]  pending_q;
    logic [63:0]          slot_time_q [NUM_CHAN];
    logic [MW-1:0]        slot_msg_q  [NUM_CHAN];
    logic [3:0]           seqno_q     [NUM_CHAN];

    logic [CW-1:0]        gch_q;
    logic [63:0]          wtime_q;
    logic [MW-1:0]        wmsg_q;
    logic [31:0]          wsid_q;
    logic [31:0]          wfc_q;
    logic [3:0]           wseq_q;

    logic [35:0]          data_q, wd;
    logic                 src_rdy_q;
    logic [NUM_CHAN-1:0]  sent_q, dropped_q;

    logic                 gnt_vld, do_grant, accept;
    logic [CW-1:0]        gnt_ch, k;
    logic [NUM_CHAN-1:0]  gnt_oh;

    assign data_o    = data_q;
    assign src_rdy_o = src_rdy_q;
    assign sent      = sent_q;
    assign dropped   = dropped_q;
    assign accept    = src_rdy_q & dst_rdy_i;

    // First pending channel at or after the round-robin pointer
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        k       = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            k = CW'((int'(rr_q) + i) % NUM_CHAN);
            if (!gnt_vld && pending_q[k]) begin
                gnt_vld = 1'b1;
                gnt_ch  = k;
            end
        end
    end

    assign do_grant = (state_q == S_IDLE) && !go_q && gnt_vld;

    always_comb begin
        gnt_oh = '0;
        if (do_grant) gnt_oh[gnt_ch] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == S_IDLE) begin
            if (go_q) begin
                state_d = (PROT_ENG_FLAGS != 0) ? S_PROT : S_HDR;
                idx_d   = '0;
            end
        end else if (accept) begin
            unique case (state_q)
                S_PROT:  state_d = S_HDR;
                S_HDR:   state_d = S_SID;
                S_SID:   state_d = S_TICS;
                S_TICS:  state_d = S_TICS2;
                S_TICS2: begin
                    state_d = S_MSG;
                    idx_d   = '0;
                end
                S_MSG: begin
                    if (idx_q == IW'(MSG_WORDS - 1)) state_d = S_FLOW;
                    else idx_d = idx_q + 1'b1;
                end
                S_FLOW:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Word presented in the state being entered; unchanged while stalled
    always_comb begin
        wd = '0;
        case (state_d)
            S_PROT:  wd = {3'b000, 1'b1, 12'h000,
                           4'(PORT_BASE + 4'(gch_q)), 16'(4 * LEN)};
            S_HDR:   wd = {3'b000, (PROT_ENG_FLAGS == 0), 12'h501,
                           wseq_q, 16'(LEN)};
            S_SID:   wd = {4'b0000, wsid_q};
            S_TICS:  wd = {4'b0000, wtime_q[63:32]};
            S_TICS2: wd = {4'b0000, wtime_q[31:0]};
            S_MSG:   wd = {4'b0000, wmsg_q[int'(idx_d)*32 +: 32]};
            S_FLOW:  wd = {4'b0010, wfc_q};
            default: wd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            go_q      <= 1'b0;
            rr_q      <= '0;
            pending_q <= '0;
            gch_q     <= '0;
            wtime_q   <= '0;
            wmsg_q    <= '0;
            wsid_q    <= '0;
            wfc_q     <= '0;
            wseq_q    <= '0;
            data_q    <= '0;
            src_rdy_q <= 1'b0;
            sent_q    <= '0;
            dropped_q <= '0;
            for (int c = 0; c < NUM_CHAN; c++) begin
                slot_time_q[c] <= '0;
                slot_msg_q[c]  <= '0;
                seqno_q[c]     <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= wd;
            src_rdy_q <= (state_d != S_IDLE);
            go_q      <= do_grant;
            sent_q    <= '0;
            dropped_q <= '0;

            if (do_grant) begin
                gch_q   <= gnt_ch;
                wtime_q <= slot_time_q[gnt_ch];
                wmsg_q  <= slot_msg_q[gnt_ch];
                wsid_q  <= streamid[int'(gnt_ch)*32 +: 32];
                wfc_q   <= seqnum[int'(gnt_ch)*32 +: 32];
                wseq_q  <= seqno_q[gnt_ch];
                rr_q    <= CW'((int'(gnt_ch) + 1) % NUM_CHAN);
            end

            if (accept && state_q == S_FLOW) begin
                sent_q[gch_q]  <= 1'b1;
                seqno_q[gch_q] <= seqno_q[gch_q] + 4'd1;
            end

            // A slot freed by this cycle's grant may take a new event
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (clear) begin
                    pending_q[c] <= 1'b0;
                end else if (trigger[c]) begin
                    if (!pending_q[c] || gnt_oh[c]) begin
                        pending_q[c]   <= 1'b1;
                        slot_time_q[c] <= vita_time;
                        slot_msg_q[c]  <= message[c*MW +: MW];
                    end else begin
                        dropped_q[c] <= 1'b1;
                    end
                end else if (gnt_oh[c]) begin
                    pending_q[c] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gen_context_pkt_mc.sv
// Directed bench for gen_context_pkt_mc: two instances
// (PROT=1/MSG=1 and PROT=0/MSG=3) driven by one linear sequence.
module tb_gen_context_pkt_mc;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic [1:0]    trigger = '0;
    logic [63:0]   message = '0;
    logic [63:0]   streamid = {32'h1111_0001, 32'h1111_0000};
    logic [63:0]   seqnum = {32'h0000_00C1, 32'h0000_00C0};
    logic [63:0]   vita_time = '0;
    logic [35:0]   data_o;
    logic          src_rdy;
    logic          dst_rdy = 1'b1;
    logic [1:0]    sent, dropped;

    logic [1:0]    trigger_b = '0;
    logic [191:0]  message_b = '0;
    logic [35:0]   data_b;
    logic          src_rdy_b;
    logic          dst_rdy_b = 1'b1;
    logic [1:0]    sent_b, dropped_b;

    int            nvec = 0;
    int            nerr = 0;
    logic [35:0]   w [16];
    logic [35:0]   e [8];
    int            wn;
    int            busy;
    logic [1:0]    sent_seen;

    gen_context_pkt_mc #(
        .NUM_CHAN(2), .MSG_WORDS(1), .PROT_ENG_FLAGS(1), .PORT_BASE(4'd3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .trigger(trigger),
        .message(message), .streamid(streamid), .seqnum(seqnum),
        .vita_time(vita_time), .data_o(data_o), .src_rdy_o(src_rdy),
        .dst_rdy_i(dst_rdy), .sent(sent), .dropped(dropped)
    );

    gen_context_pkt_mc #(
        .NUM_CHAN(2), .MSG_WORDS(3), .PROT_ENG_FLAGS(0), .PORT_BASE(4'd3)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .trigger(trigger_b),
        .message(message_b), .streamid(streamid), .seqnum(seqnum),
        .vita_time(vita_time), .data_o(data_b), .src_rdy_o(src_rdy_b),
        .dst_rdy_i(dst_rdy_b), .sent(sent_b), .dropped(dropped_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic get_pkt(input int len, input bit tog);
        int cyc;
        wn  = 0;
        cyc = 0;
        while (wn < len && cyc < 300) begin
            dst_rdy = tog ? ~dst_rdy : 1'b1;
            if (src_rdy && dst_rdy) begin
                w[wn] = data_o;
                wn++;
            end
            tick();
            cyc++;
        end
        sent_seen = sent;
        dst_rdy = 1'b1;
        check("pkt_words", 64'(wn), 64'(len));
    endtask

    task automatic idle_watch(input string tag);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (src_rdy) busy++;
            tick();
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_src_rdy", 64'(src_rdy), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_sent", 64'(sent), 64'd0);
        check("rst_dropped", 64'(dropped), 64'd0);
        reset_n = 1'b1;
        tick();

        // single packet, latency and full word sequence
        vita_time = 64'h0000_0001_0000_0002;
        message[31:0] = 32'h0000_DEAD;
        trigger = 2'b01;
        tick();
        trigger = 2'b00;
        check("lat_k", 64'(src_rdy), 64'd0);
        tick();
        check("lat_k1", 64'(src_rdy), 64'd0);
        tick();
        check("lat_k2", 64'(src_rdy), 64'd1);
        e[0] = 36'h1_0003_0018; e[1] = 36'h0_5010_0006;
        e[2] = 36'h0_1111_0000; e[3] = 36'h0_0000_0001;
        e[4] = 36'h0_0000_0002; e[5] = 36'h0_0000_DEAD;
        e[6] = 36'h2_0000_00C0;
        get_pkt(7, 1'b0);
        for (int i = 0; i < 7; i++) check($sformatf("t1_w%0d", i), 64'(w[i]), 64'(e[i]));
        check("t1_sent", 64'(sent_seen), 64'd1);
        tick();
        check("t1_sent_pulse", 64'(sent), 64'd0);

        // simultaneous triggers, round-robin order
        do_reset();
        vita_time = 64'h0000_000A_0000_000B;
        message = {32'h0000_2001, 32'h0000_1000};
        for (int r = 0; r < 2; r++) begin
            trigger = 2'b11;
            tick();
            trigger = 2'b00;
            get_pkt(7, 1'b0);
            check($sformatf("t2_r%0d_c0_prot", r), 64'(w[0]), 64'h1_0003_0018);
            check($sformatf("t2_r%0d_c0_hdr", r), 64'(w[1]),
                  64'(36'h0_5010_0006 | (36'(r) << 16)));
            check($sformatf("t2_r%0d_c0_msg", r), 64'(w[5]), 64'h0_0000_1000);
            check($sformatf("t2_r%0d_c0_sent", r), 64'(sent_seen), 64'd1);
            check($sformatf("t2_r%0d_gap", r), 64'(src_rdy), 64'd0);
            get_pkt(7, 1'b0);
            check($sformatf("t2_r%0d_c1_prot", r), 64'(w[0]), 64'h1_0004_0018);
            check($sformatf("t2_r%0d_c1_hdr", r), 64'(w[1]),
                  64'(36'h0_5010_0006 | (36'(r) << 16)));
            check($sformatf("t2_r%0d_c1_sid", r), 64'(w[2]), 64'h0_1111_0001);
            check($sformatf("t2_r%0d_c1_msg", r), 64'(w[5]), 64'h0_0000_2001);
            check($sformatf("t2_r%0d_c1_flow", r), 64'(w[6]), 64'h2_0000_00C1);
            check($sformatf("t2_r%0d_c1_sent", r), 64'(sent_seen), 64'd2);
        end

        // backpressure toggling every cycle
        vita_time = 64'h0000_0003_0000_0004;
        message[31:0] = 32'h0000_BEEF;
        trigger = 2'b01;
        tick();
        trigger = 2'b00;
        e[0] = 36'h1_0003_0018; e[1] = 36'h0_5012_0006;
        e[2] = 36'h0_1111_0000; e[3] = 36'h0_0000_0003;
        e[4] = 36'h0_0000_0004; e[5] = 36'h0_0000_BEEF;
        e[6] = 36'h2_0000_00C0;
        get_pkt(7, 1'b1);
        for (int i = 0; i < 7; i++) check($sformatf("t3_w%0d", i), 64'(w[i]), 64'(e[i]));

        // drop on a channel that is already pending
        dst_rdy = 1'b0;
        message[31:0] = 32'h0000_5555;
        trigger = 2'b01;
        tick();
        trigger = 2'b00;
        tick();
        message[63:32] = 32'h0000_3333;
        trigger = 2'b10;
        tick();
        check("t4_no_drop_first", 64'(dropped), 64'd0);
        message[63:32] = 32'h0000_4444;
        trigger = 2'b10;
        tick();
        trigger = 2'b00;
        check("t4_dropped", 64'(dropped), 64'd2);
        tick();
        check("t4_dropped_pulse", 64'(dropped), 64'd0);
        get_pkt(7, 1'b0);
        check("t4_c0_hdr", 64'(w[1]), 64'h0_5013_0006);
        check("t4_c0_msg", 64'(w[5]), 64'h0_0000_5555);
        get_pkt(7, 1'b0);
        check("t4_c1_prot", 64'(w[0]), 64'h1_0004_0018);
        check("t4_c1_hdr", 64'(w[1]), 64'h0_5012_0006);
        check("t4_c1_msg", 64'(w[5]), 64'h0_0000_3333);
        idle_watch("t4_no_second");

        // header seqno wraps after 16 packets
        do_reset();
        for (int i = 0; i < 17; i++) begin
            message[31:0] = 32'(i);
            trigger = 2'b01;
            tick();
            trigger = 2'b00;
            get_pkt(7, 1'b0);
            check($sformatf("t5_hdr%0d", i), 64'(w[1]),
                  64'({4'h0, 12'h501, 4'(i), 16'h0006}));
        end

        // no protocol word, three message words
        vita_time = 64'h0000_0007_0000_0008;
        message_b[95:0] = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
        trigger_b = 2'b01;
        tick();
        trigger_b = 2'b00;
        e[0] = 36'h1_5010_0008; e[1] = 36'h0_1111_0000;
        e[2] = 36'h0_0000_0007; e[3] = 36'h0_0000_0008;
        e[4] = 36'h0_0000_0011; e[5] = 36'h0_0000_0022;
        e[6] = 36'h0_0000_0033; e[7] = 36'h2_0000_00C0;
        wn = 0;
        for (int cyc = 0; cyc < 60 && wn < 8; cyc++) begin
            if (src_rdy_b) begin
                w[wn] = data_b;
                wn++;
            end
            tick();
        end
        check("t5b_words", 64'(wn), 64'd8);
        for (int i = 0; i < 8; i++) check($sformatf("t5b_w%0d", i), 64'(w[i]), 64'(e[i]));
        check("t5b_sent", 64'(sent_b), 64'd1);

        // clear drops pending ch1 but ch0 completes
        dst_rdy = 1'b0;
        message[31:0] = 32'h0000_6666;
        trigger = 2'b01;
        tick();
        trigger = 2'b00;
        tick();
        trigger = 2'b10;
        tick();
        trigger = 2'b00;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        get_pkt(7, 1'b0);
        check("t6_c0_hdr", 64'(w[1]), 64'h0_5011_0006);
        check("t6_c0_msg", 64'(w[5]), 64'h0_0000_6666);
        idle_watch("t6_no_c1");

        // asynchronous reset in the middle of a packet
        dst_rdy = 1'b0;
        trigger = 2'b01;
        tick();
        trigger = 2'b00;
        tick();
        tick();
        check("t6_inflight", 64'(src_rdy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_rdy", 64'(src_rdy), 64'd0);
        check("t6_async_data", 64'(data_o), 64'd0);
        tick();
        reset_n = 1'b1;
        dst_rdy = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
